// File: rtl/div_pkg.sv
// Shared definitions for the sequential q*d+r dividend reconstructor.
// Holds the FSM state type, the default widths and the bit-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DIV_W     = 8;
    localparam int DIV_ACC_W = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_W);

endpackage

// File: rtl/div_recon_err.sv
// Error metrics for the reconstructor: |n_ref - n| captured per result,
// plus saturating running error sum and consumed-result count.
module div_recon_err
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int ACC_W = DIV_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               pop,
    input  logic [2*W-1:0]     n_ref,
    input  logic [2*W-1:0]     n_val,
    output logic [2*W-1:0]     err,
    output logic [ACC_W-1:0]   err_sum,
    output logic [ACC_W-1:0]   err_cnt
);

    logic [ACC_W:0] sum_ext;
    logic [ACC_W:0] cnt_ext;

    // One extra bit catches the carry so both accumulators can clamp at all-ones.
    always_comb begin
        sum_ext = {1'b0, err_sum} + (ACC_W+1)'(err);
        cnt_ext = {1'b0, err_cnt} + (ACC_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= '0;
            err_sum <= '0;
            err_cnt <= '0;
        end else begin
            if (load) begin
                err <= (n_ref >= n_val) ? (n_ref - n_val) : (n_val - n_ref);
            end
            if (pop) begin
                err_sum <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
                err_cnt <= cnt_ext[ACC_W] ? '1 : cnt_ext[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/div_reconstruct_seq.sv
// Rebuilds n = q*d + r with a W-cycle shift-add, one result per W+2 cycles.
// Define DIV_RECON_ERR_EN to add |n_ref - n| error metrics via div_recon_err.
module div_reconstruct_seq
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int ACC_W = DIV_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       q,
    input  logic [W-1:0]       d,
    input  logic [W-1:0]       r,
    input  logic [2*W-1:0]     n_ref,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     n_out,
    output logic [2*W-1:0]     err,
    output logic [ACC_W-1:0]   err_sum,
    output logic [ACC_W-1:0]   err_cnt
);

    localparam int CNT_W = cnt_width(W);

    state_t             state;
    logic [2*W-1:0]     acc;
    logic [2*W-1:0]     mcand;
    logic [W-1:0]       mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2*W-1:0]     acc_next;
    logic               last;

    // The final partial product is folded in on the same edge that enters DONE.
    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
        last     = (cnt == CNT_W'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            n_out     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= (2*W)'(r);
                        mcand    <= (2*W)'(d);
                        mplier   <= q;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        n_out     <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIV_RECON_ERR_EN
    logic [2*W-1:0] n_ref_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_ref_q <= '0;
        end else if (state == IDLE && in_valid) begin
            n_ref_q <= n_ref;
        end
    end

    div_recon_err #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_err (
        .clk     (clk),
        .rst     (rst),
        .load    (state == RUN && last),
        .pop     (out_valid && out_ready),
        .n_ref   (n_ref_q),
        .n_val   (acc_next),
        .err     (err),
        .err_sum (err_sum),
        .err_cnt (err_cnt)
    );
`else
    logic unused_n_ref;

    assign unused_n_ref = ^n_ref;
    assign err          = '0;
    assign err_sum      = '0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// Self-checking bench for div_reconstruct_seq: arithmetic reference model with
// per-cycle compare, plus directed vectors with hand-computed results.
module tb_div_reconstruct_seq;

    localparam int W     = 8;
    localparam int ACC_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [W-1:0]      q = '0;
    logic [W-1:0]      d = '0;
    logic [W-1:0]      r = '0;
    logic [2*W-1:0]    n_ref = '0;
    logic              in_ready;
    logic              out_valid;
    logic [2*W-1:0]    n_out;
    logic [2*W-1:0]    err;
    logic [ACC_W-1:0]  err_sum;
    logic [ACC_W-1:0]  err_cnt;

    div_reconstruct_seq #(
        .W     (W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .r         (r),
        .n_ref     (n_ref),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_out     (n_out),
        .err       (err),
        .err_sum   (err_sum),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: result = q*d + r, valid W cycles after the accepting edge.
    bit              m_ready = 1'b1;
    bit              m_valid = 1'b0;
    int              m_count = 0;
    logic [2*W-1:0]  m_pend  = '0;
    logic [2*W-1:0]  m_pref  = '0;
    logic [2*W-1:0]  m_n     = '0;
    logic [2*W-1:0]  m_err   = '0;
    longint unsigned m_sum   = 0;
    longint unsigned m_cnt   = 0;
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 1;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_count = 0;
            m_n     = '0;
            m_err   = '0;
            m_sum   = 0;
            m_cnt   = 0;
        end else if (m_count > 0) begin
            m_count--;
            if (m_count == 0) begin
                m_valid = 1'b1;
                m_n     = m_pend;
`ifdef DIV_RECON_ERR_EN
                m_err   = (m_pref >= m_pend) ? m_pref - m_pend : m_pend - m_pref;
`endif
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
`ifdef DIV_RECON_ERR_EN
                m_sum = (m_sum + m_err > ACC_MAX) ? ACC_MAX : m_sum + m_err;
                m_cnt = (m_cnt + 1 > ACC_MAX) ? ACC_MAX : m_cnt + 1;
`endif
            end
        end else if (m_ready && in_valid) begin
            m_pend  = (2*W)'(q) * (2*W)'(d) + (2*W)'(r);
            m_pref  = n_ref;
            m_count = W;
            m_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready", in_ready, m_ready);
            check("cyc_out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("cyc_n_out", n_out, m_n);
                check("cyc_err", err, m_err);
            end
            check("cyc_err_sum", err_sum, m_sum);
            check("cyc_err_cnt", err_cnt, m_cnt);
        end
    end

    // Drive one operation; report the result latency and check n_out against a literal.
    task automatic run_op(input logic [W-1:0] tq, input logic [W-1:0] td, input logic [W-1:0] tr,
                          input logic [2*W-1:0] tref, input logic [2*W-1:0] exp_n,
                          input string name, input bit pop);
        int edges;
        @(posedge clk);
        #1;
        q = tq; d = td; r = tr; n_ref = tref;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 0;
        @(negedge clk);
        while (!out_valid && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        check({name, "_latency"}, edges, W);
        check({name, "_n_out"}, n_out, exp_n);
        if (pop) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_ready_after_pop"}, in_ready, 1'b1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_n_out", n_out, 16'h0000);
        check("reset_err", err, 16'h0000);
        check("reset_err_sum", err_sum, 32'd0);
        check("reset_err_cnt", err_cnt, 32'd0);

        run_op(8'h0C, 8'h0A, 8'h03, 16'h0000, 16'h007B, "basic", 1'b1);
        run_op(8'hFF, 8'hFF, 8'hFF, 16'h0000, 16'hFF00, "max", 1'b1);
        run_op(8'h55, 8'h00, 8'h07, 16'h0000, 16'h0007, "d_zero", 1'b1);
        run_op(8'h00, 8'h9C, 8'h11, 16'h0000, 16'h0011, "q_zero", 1'b1);
        run_op(8'h03, 8'h05, 8'h20, 16'h0000, 16'h002F, "r_gt_d", 1'b1);

        // Backpressure: hold DONE for 5 cycles, pulse in_valid which must be ignored.
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, 8'h05, 16'h0000, 16'h03AD, "hold", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                q = 8'hAA; d = 8'hBB; r = 8'hCC;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_n_out", n_out, 16'h03AD);
            check("hold_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("hold_ready_after_pop", in_ready, 1'b1);
        run_op(8'h00, 8'h9C, 8'h11, 16'h0000, 16'h0011, "after_hold", 1'b1);

        // Abort: reset during the 4th RUN cycle discards the operation.
        @(posedge clk);
        #1;
        q = 8'h0F; d = 8'h0F; r = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_n_out", n_out, 16'h0000);
        repeat (12) @(negedge clk);
        check("abort_no_result", out_valid, 1'b0);

        // Error metrics from a freshly reset state.
        run_op(8'h0C, 8'h0A, 8'h03, 16'h0080, 16'h007B, "err1", 1'b1);
`ifdef DIV_RECON_ERR_EN
        check("err1_err", err, 16'h0005);
        check("err1_sum", err_sum, 32'd5);
        check("err1_cnt", err_cnt, 32'd1);
`else
        check("err1_err", err, 16'h0000);
        check("err1_sum", err_sum, 32'd0);
        check("err1_cnt", err_cnt, 32'd0);
`endif
        run_op(8'h0C, 8'h0A, 8'h03, 16'h0070, 16'h007B, "err2", 1'b1);
`ifdef DIV_RECON_ERR_EN
        check("err2_err", err, 16'h000B);
        check("err2_sum", err_sum, 32'd16);
        check("err2_cnt", err_cnt, 32'd2);
`else
        check("err2_err", err, 16'h0000);
        check("err2_sum", err_sum, 32'd0);
        check("err2_cnt", err_cnt, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
